// File: rtl/fp_pkg.sv
// Shared types and constants for the single-precision multiplier.
// FSM state encoding and IEEE-754 field layout live here.
package fp_pkg;

  localparam int unsigned EXP_LEN      = 8;
  localparam int unsigned MANTISSA_LEN = 23;
  localparam int unsigned DATA_WIDTH   = 1 + EXP_LEN + MANTISSA_LEN;
  localparam int          BIAS         = (1 << (EXP_LEN - 1)) - 1;

  typedef struct packed {
    logic                    sign;
    logic [EXP_LEN-1:0]      exp;
    logic [MANTISSA_LEN-1:0] frac;
  } fp_t;

  localparam fp_t FP_QNAN = '{sign: 1'b0, exp: '1, frac: {1'b1, {(MANTISSA_LEN-1){1'b0}}}};
  localparam fp_t FP_POS_INF = '{sign: 1'b0, exp: '1, frac: '0};

  typedef enum logic [2:0] {
    StIdle,
    StUnpack,
    StMult,
    StNorm,
    StRound,
    StDone
  } mult_state_t;

endpackage

// File: rtl/fp_classify.sv
// Combinational IEEE-754 operand classifier; subnormals report as zero
// so the multiplier flushes them.
module fp_classify #(
  parameter int unsigned ExpLen  = fp_pkg::EXP_LEN,
  parameter int unsigned FracLen = fp_pkg::MANTISSA_LEN
) (
  input  logic [ExpLen-1:0]  exp_i,
  input  logic [FracLen-1:0] frac_i,
  output logic               is_zero_o,
  output logic               is_inf_o,
  output logic               is_nan_o
);

  logic exp_max;
  logic frac_nz;

  assign exp_max   = &exp_i;
  assign frac_nz   = |frac_i;
  assign is_zero_o = (exp_i == '0);
  assign is_inf_o  = exp_max & ~frac_nz;
  assign is_nan_o  = exp_max & frac_nz;

endmodule

// File: rtl/fp_mult_unit.sv
// Iterative shift-add IEEE-754 multiplier with constant latency MANTISSA_LEN+5.
// Define FP_MULT_ROUND_NEAREST_EN for round-to-nearest-even; otherwise truncates.
module fp_mult_unit #(
  parameter int unsigned EXP_LEN      = fp_pkg::EXP_LEN,
  parameter int unsigned MANTISSA_LEN = fp_pkg::MANTISSA_LEN,
  parameter int unsigned DATA_WIDTH   = 1 + EXP_LEN + MANTISSA_LEN
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  mult_start,
  input  logic [DATA_WIDTH-1:0] mult_operand_a,
  input  logic [DATA_WIDTH-1:0] mult_operand_b,
  output logic [DATA_WIDTH-1:0] mult_result,
  output logic                  mult_result_ready
);
  import fp_pkg::*;

  localparam int unsigned MantW = MANTISSA_LEN + 1;
  localparam int unsigned ProdW = 2 * MantW;
  localparam int unsigned ExpW  = EXP_LEN + 2;
  localparam int unsigned CntW  = $clog2(MantW + 1);
  localparam logic signed [ExpW-1:0] ExpBias = ExpW'((1 << (EXP_LEN - 1)) - 1);
  localparam logic signed [ExpW-1:0] ExpMax  = ExpW'((1 << EXP_LEN) - 1);

  localparam logic [DATA_WIDTH-1:0] QNan =
    {1'b0, {EXP_LEN{1'b1}}, 1'b1, {(MANTISSA_LEN-1){1'b0}}};

  mult_state_t state_q, state_d;

  logic [DATA_WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic                    sign_q, sign_d;
  logic signed [ExpW-1:0]  exp_q, exp_d;
  logic [MantW-1:0]        ma_q, ma_d, mb_q, mb_d;
  logic [ProdW-1:0]        prod_q, prod_d;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic [MANTISSA_LEN-1:0] frac_q, frac_d;
  logic                    guard_q, guard_d, round_q, round_d, sticky_q, sticky_d;
  logic                    nan_q, nan_d, inf_q, inf_d, zero_q, zero_d;
  logic [DATA_WIDTH-1:0]   res_q, res_d, result_q, result_d;
  logic                    ready_q, ready_d;

  logic a_zero, a_inf, a_nan, b_zero, b_inf, b_nan;

  fp_classify #(
    .ExpLen (EXP_LEN),
    .FracLen(MANTISSA_LEN)
  ) u_class_a (
    .exp_i    (a_q[DATA_WIDTH-2 -: EXP_LEN]),
    .frac_i   (a_q[MANTISSA_LEN-1:0]),
    .is_zero_o(a_zero),
    .is_inf_o (a_inf),
    .is_nan_o (a_nan)
  );

  fp_classify #(
    .ExpLen (EXP_LEN),
    .FracLen(MANTISSA_LEN)
  ) u_class_b (
    .exp_i    (b_q[DATA_WIDTH-2 -: EXP_LEN]),
    .frac_i   (b_q[MANTISSA_LEN-1:0]),
    .is_zero_o(b_zero),
    .is_inf_o (b_inf),
    .is_nan_o (b_nan)
  );

  // One partial product per clock: add into the upper half, then shift right.
  logic [MantW:0] step_sum;
  assign step_sum = {1'b0, prod_q[ProdW-1:MantW]} + (mb_q[0] ? {1'b0, ma_q} : '0);

  logic round_inc;
`ifdef FP_MULT_ROUND_NEAREST_EN
  assign round_inc = guard_q & (round_q | sticky_q | frac_q[0]);
`else
  logic unused_grs;
  assign unused_grs = ^{guard_q, round_q, sticky_q};
  assign round_inc  = 1'b0;
`endif

  logic                    frac_carry;
  logic [MANTISSA_LEN-1:0] frac_rnd;
  logic signed [ExpW-1:0]  exp_rnd;

  // An all-ones fraction rounding up wraps to zero, i.e. 1.0 at the next exponent.
  assign {frac_carry, frac_rnd} = {1'b0, frac_q} + (MANTISSA_LEN + 1)'(round_inc);
  assign exp_rnd = exp_q + ExpW'(frac_carry);

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    sign_d   = sign_q;
    exp_d    = exp_q;
    ma_d     = ma_q;
    mb_d     = mb_q;
    prod_d   = prod_q;
    cnt_d    = cnt_q;
    frac_d   = frac_q;
    guard_d  = guard_q;
    round_d  = round_q;
    sticky_d = sticky_q;
    nan_d    = nan_q;
    inf_d    = inf_q;
    zero_d   = zero_q;
    res_d    = res_q;
    result_d = result_q;
    ready_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (mult_start) begin
          a_d     = mult_operand_a;
          b_d     = mult_operand_b;
          state_d = StUnpack;
        end
      end
      StUnpack: begin
        sign_d  = a_q[DATA_WIDTH-1] ^ b_q[DATA_WIDTH-1];
        exp_d   = $signed({2'b00, a_q[DATA_WIDTH-2 -: EXP_LEN]})
                + $signed({2'b00, b_q[DATA_WIDTH-2 -: EXP_LEN]}) - ExpBias;
        ma_d    = {1'b1, a_q[MANTISSA_LEN-1:0]};
        mb_d    = {1'b1, b_q[MANTISSA_LEN-1:0]};
        prod_d  = '0;
        cnt_d   = '0;
        nan_d   = a_nan | b_nan | (a_inf & b_zero) | (a_zero & b_inf);
        inf_d   = a_inf | b_inf;
        zero_d  = a_zero | b_zero;
        state_d = StMult;
      end
      StMult: begin
        prod_d = {step_sum, prod_q[MantW-1:1]};
        mb_d   = mb_q >> 1;
        cnt_d  = cnt_q + CntW'(1);
        if (cnt_q == CntW'(MANTISSA_LEN)) begin
          state_d = StNorm;
        end
      end
      StNorm: begin
        if (prod_q[ProdW-1]) begin
          frac_d   = prod_q[ProdW-2 -: MANTISSA_LEN];
          guard_d  = prod_q[MantW-1];
          round_d  = prod_q[MantW-2];
          sticky_d = |prod_q[MantW-3:0];
          exp_d    = exp_q + ExpW'(1);
        end else begin
          frac_d   = prod_q[ProdW-3 -: MANTISSA_LEN];
          guard_d  = prod_q[MantW-2];
          round_d  = prod_q[MantW-3];
          sticky_d = |prod_q[MantW-4:0];
        end
        state_d = StRound;
      end
      StRound: begin
        if (nan_q) begin
          res_d = QNan;
        end else if (inf_q || exp_rnd >= ExpMax) begin
          res_d = {sign_q, {EXP_LEN{1'b1}}, {MANTISSA_LEN{1'b0}}};
        end else if (zero_q || exp_rnd <= 0) begin
          res_d = {sign_q, {(DATA_WIDTH-1){1'b0}}};
        end else begin
          res_d = {sign_q, exp_rnd[EXP_LEN-1:0], frac_rnd};
        end
        state_d = StDone;
      end
      StDone: begin
        result_d = res_q;
        ready_d  = 1'b1;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= StIdle;
      a_q      <= '0;
      b_q      <= '0;
      sign_q   <= 1'b0;
      exp_q    <= '0;
      ma_q     <= '0;
      mb_q     <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
      frac_q   <= '0;
      guard_q  <= 1'b0;
      round_q  <= 1'b0;
      sticky_q <= 1'b0;
      nan_q    <= 1'b0;
      inf_q    <= 1'b0;
      zero_q   <= 1'b0;
      res_q    <= '0;
      result_q <= '0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sign_q   <= sign_d;
      exp_q    <= exp_d;
      ma_q     <= ma_d;
      mb_q     <= mb_d;
      prod_q   <= prod_d;
      cnt_q    <= cnt_d;
      frac_q   <= frac_d;
      guard_q  <= guard_d;
      round_q  <= round_d;
      sticky_q <= sticky_d;
      nan_q    <= nan_d;
      inf_q    <= inf_d;
      zero_q   <= zero_d;
      res_q    <= res_d;
      result_q <= result_d;
      ready_q  <= ready_d;
    end
  end

  assign mult_result       = result_q;
  assign mult_result_ready = ready_q;

endmodule

// File: tb/tb_fp_mult_unit.sv
// Directed bench for fp_mult_unit: latency, back-to-back, specials, rounding,
// busy-start rejection and mid-operation reset.
module tb_fp_mult_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [31:0] result;
  logic        ready;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  fp_mult_unit dut (
    .clock            (clock),
    .reset            (reset),
    .mult_start       (start),
    .mult_operand_a   (op_a),
    .mult_operand_b   (op_b),
    .mult_result      (result),
    .mult_result_ready(ready)
  );

  // Start sampled at edge 0; returns the cycle index of the first ready pulse (-1 if none).
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input int extra_at,
                        input int reset_at, input int max_cycles, output int ready_cycle,
                        output logic [31:0] res, output bit early_change);
    logic [31:0] held;
    ready_cycle  = -1;
    res          = '0;
    early_change = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    start = 1'b1;
    op_a  = a;
    op_b  = b;
    @(posedge clock);
    #1;
    held = result;
    for (int i = 1; i <= max_cycles; i++) begin
      @(negedge clock);
      start = (i == extra_at);
      if (i == extra_at) begin
        op_a = ~a;
        op_b = 32'h40800000;
      end
      reset = (i == reset_at);
      @(posedge clock);
      #1;
      if (ready) begin
        ready_cycle = i;
        res         = result;
        break;
      end
      if (result !== held) early_change = 1'b1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    op_a  = '0;
    op_b  = '0;
    repeat (2) @(posedge clock);
    #1;
    n_cmp++;
    if (result !== 32'h0) begin
      n_bad++;
      $display("FAIL reset_result: got %h want 00000000", result);
    end
    n_cmp++;
    if (ready !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_ready: got %b want 0", ready);
    end
  endtask

  task automatic test_basic();
    int cyc;
    logic [31:0] res;
    bit early;
    run_op(32'h40000000, 32'h40400000, 0, 0, 40, cyc, res, early);
    n_cmp++;
    if (cyc !== 28) begin
      n_bad++;
      $display("FAIL basic_latency: got %0d want 28", cyc);
    end
    n_cmp++;
    if (res !== 32'h40C00000) begin
      n_bad++;
      $display("FAIL basic_result: got %h want 40c00000", res);
    end
    n_cmp++;
    if (early !== 1'b0) begin
      n_bad++;
      $display("FAIL basic_early_update: got %b want 0", early);
    end
    @(posedge clock);
    #1;
    n_cmp++;
    if (ready !== 1'b0) begin
      n_bad++;
      $display("FAIL basic_pulse_width: got %b want 0", ready);
    end
    n_cmp++;
    if (result !== 32'h40C00000) begin
      n_bad++;
      $display("FAIL basic_result_hold: got %h want 40c00000", result);
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    logic [31:0] res;
    bit early;
    run_op(32'h3FC00000, 32'hC0200000, 0, 0, 40, cyc, res, early);
    n_cmp++;
    if (cyc !== 28) begin
      n_bad++;
      $display("FAIL b2b_first_latency: got %0d want 28", cyc);
    end
    n_cmp++;
    if (res !== 32'hC0700000) begin
      n_bad++;
      $display("FAIL b2b_first_result: got %h want c0700000", res);
    end
    run_op(32'h3F800000, 32'h3F800000, 0, 0, 40, cyc, res, early);
    n_cmp++;
    if (cyc !== 28) begin
      n_bad++;
      $display("FAIL b2b_second_latency: got %0d want 28", cyc);
    end
    n_cmp++;
    if (res !== 32'h3F800000) begin
      n_bad++;
      $display("FAIL b2b_second_result: got %h want 3f800000", res);
    end
    n_cmp++;
    if (early !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_early_update: got %b want 0", early);
    end
  endtask

  task automatic test_specials();
    logic [31:0] va [4] = '{32'h7F800000, 32'hFF800000, 32'h80000000, 32'h7F000000};
    logic [31:0] vb [4] = '{32'h00000000, 32'h40000000, 32'h40000000, 32'h7F000000};
    logic [31:0] ve [4] = '{32'h7FC00000, 32'hFF800000, 32'h80000000, 32'h7F800000};
    int cyc;
    logic [31:0] res;
    bit early;
    for (int k = 0; k < 4; k++) begin
      run_op(va[k], vb[k], 0, 0, 40, cyc, res, early);
      n_cmp++;
      if (cyc !== 28) begin
        n_bad++;
        $display("FAIL special%0d_latency: got %0d want 28", k, cyc);
      end
      n_cmp++;
      if (res !== ve[k]) begin
        n_bad++;
        $display("FAIL special%0d_result: got %h want %h", k, res, ve[k]);
      end
    end
  endtask

  task automatic test_rounding();
    int cyc;
    logic [31:0] res;
    logic [31:0] want;
    bit early;
`ifdef FP_MULT_ROUND_NEAREST_EN
    want = 32'h3FC00002;
`else
    want = 32'h3FC00001;
`endif
    run_op(32'h3F800001, 32'h3FC00000, 0, 0, 40, cyc, res, early);
    n_cmp++;
    if (cyc !== 28) begin
      n_bad++;
      $display("FAIL round_latency: got %0d want 28", cyc);
    end
    n_cmp++;
    if (res !== want) begin
      n_bad++;
      $display("FAIL round_result: got %h want %h", res, want);
    end
  endtask

  task automatic test_busy();
    int cyc;
    logic [31:0] res;
    bit early;
    run_op(32'h40000000, 32'h40400000, 5, 0, 40, cyc, res, early);
    n_cmp++;
    if (cyc !== 28) begin
      n_bad++;
      $display("FAIL busy_latency: got %0d want 28", cyc);
    end
    n_cmp++;
    if (res !== 32'h40C00000) begin
      n_bad++;
      $display("FAIL busy_result: got %h want 40c00000", res);
    end
    n_cmp++;
    if (early !== 1'b0) begin
      n_bad++;
      $display("FAIL busy_early_update: got %b want 0", early);
    end
  endtask

  task automatic test_abort();
    int cyc;
    logic [31:0] res;
    bit early;
    run_op(32'h40000000, 32'h40400000, 0, 10, 10, cyc, res, early);
    n_cmp++;
    if (cyc !== -1) begin
      n_bad++;
      $display("FAIL abort_no_pulse: got ready at cycle %0d want none", cyc);
    end
    n_cmp++;
    if (result !== 32'h0) begin
      n_bad++;
      $display("FAIL abort_result: got %h want 00000000", result);
    end
    n_cmp++;
    if (ready !== 1'b0) begin
      n_bad++;
      $display("FAIL abort_ready: got %b want 0", ready);
    end
    // Start driven alongside reset release, so it lands the cycle after reset.
    run_op(32'h3FC00000, 32'h3FC00000, 0, 0, 40, cyc, res, early);
    n_cmp++;
    if (cyc !== 28) begin
      n_bad++;
      $display("FAIL abort_restart_latency: got %0d want 28", cyc);
    end
    n_cmp++;
    if (res !== 32'h40100000) begin
      n_bad++;
      $display("FAIL abort_restart_result: got %h want 40100000", res);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_specials();
    test_rounding();
    test_busy();
    test_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
